// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: runs one TLBP/TLBR/TLBWI/TLBWR against the TLB ports
// per request and owns the CP0 Random and Wired counters.
package tlb_params;

   typedef struct packed {
      logic [18:0] virtual_page_number;
      logic [7:0]  asid;
      logic        is_odd_page;
   } search_request_t;

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  cache;
      logic        dirty;
      logic        valid;
   } tlb_page_t;

   typedef struct packed {
      logic [18:0] virtual_page_number;
      logic [7:0]  asid;
      logic        is_global;
      tlb_page_t   even_page;
      tlb_page_t   odd_page;
   } tlb_request_t;

   // index is wide enough for up to 256 entries; users keep the low IW bits
   typedef struct packed {
      logic         found;
      logic [7:0]   index;
      tlb_request_t entry;
   } search_result_t;

endpackage

module tlb_op_ctrl #(
   parameter int TLB_NUM = 16,
   localparam int IW = $clog2(TLB_NUM)
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        op_valid,
   output logic                        op_ready,
   input  logic [1:0]                  op_code,
   input  logic [IW-1:0]               op_index,
   input  tlb_params::search_request_t op_search,
   input  tlb_params::tlb_request_t    op_entry,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [1:0]                  resp_op,
   output logic                        resp_probe_fail,
   output logic [IW-1:0]               resp_index,
   output tlb_params::tlb_request_t    resp_entry,
   input  logic                        wired_we,
   input  logic [IW-1:0]               wired_wdata,
   output logic [IW-1:0]               random_value,
   output logic [IW-1:0]               wired_value,
   output tlb_params::search_request_t tlb_search,
   input  tlb_params::search_result_t  tlb_search_result,
   output logic                        tlb_write_enabled,
   output logic [IW-1:0]               tlb_write_index,
   output tlb_params::tlb_request_t    tlb_write_data,
   output logic [IW-1:0]               tlb_read_index,
   input  tlb_params::tlb_request_t    tlb_read_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_TLBP  = 2'd0;
   localparam logic [1:0] OP_TLBR  = 2'd1;
   localparam logic [1:0] OP_TLBWR = 2'd3;
   localparam logic [IW-1:0] TOP_INDEX = IW'(TLB_NUM - 1);

   state_t                      state;
   logic [1:0]                  op_q;
   logic [IW-1:0]               index_q;
   tlb_params::search_request_t search_q;
   tlb_params::tlb_request_t    entry_q;
   logic [IW-1:0]               random_q;
   logic [IW-1:0]               wired_q;

   logic unused_search_bits;
   assign unused_search_bits = ^{tlb_search_result.entry, tlb_search_result.index};

   assign op_ready        = (state == IDLE);
   assign resp_op         = op_q;
   assign random_value    = random_q;
   assign wired_value     = wired_q;
   assign tlb_search      = search_q;
   assign tlb_read_index  = index_q;
   assign tlb_write_index = index_q;
   assign tlb_write_data  = entry_q;

   // Random free-runs down to Wired and wraps to the top; a Wired write restarts it
   // from the top, and TLBWR samples it in the accept cycle before any such restart.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         op_q              <= '0;
         index_q           <= '0;
         search_q          <= '0;
         entry_q           <= '0;
         random_q          <= TOP_INDEX;
         wired_q           <= '0;
         resp_valid        <= 1'b0;
         resp_probe_fail   <= 1'b0;
         resp_index        <= '0;
         resp_entry        <= '0;
         tlb_write_enabled <= 1'b0;
      end else begin
         if (wired_we || (random_q <= wired_q)) begin
            random_q <= TOP_INDEX;
         end else begin
            random_q <= random_q - 1'b1;
         end
         if (wired_we) begin
            wired_q <= wired_wdata;
         end

         case (state)
            IDLE: begin
               if (op_valid) begin
                  op_q              <= op_code;
                  search_q          <= op_search;
                  entry_q           <= op_entry;
                  index_q           <= (op_code == OP_TLBWR) ? random_q : op_index;
                  tlb_write_enabled <= op_code[1];
                  state             <= EXEC;
               end
            end
            EXEC: begin
               tlb_write_enabled <= 1'b0;
               resp_valid        <= 1'b1;
               state             <= RESP;
               case (op_q)
                  OP_TLBP: begin
                     resp_probe_fail <= ~tlb_search_result.found;
                     resp_index      <= tlb_search_result.found ?
                                        tlb_search_result.index[IW-1:0] : '0;
                     resp_entry      <= '0;
                  end
                  OP_TLBR: begin
                     resp_probe_fail <= 1'b0;
                     resp_index      <= index_q;
                     resp_entry      <= tlb_read_data;
                  end
                  default: begin
                     resp_probe_fail <= 1'b0;
                     resp_index      <= index_q;
                     resp_entry      <= '0;
                  end
               endcase
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               resp_valid        <= 1'b0;
               tlb_write_enabled <= 1'b0;
               state             <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural TLB on its ports.
module tb_tlb_op_ctrl;
   import tlb_params::*;

   localparam int TLB_NUM = 16;
   localparam int IW = 4;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            op_valid = 1'b0;
   logic            op_ready;
   logic [1:0]      op_code = '0;
   logic [IW-1:0]   op_index = '0;
   search_request_t op_search = '0;
   tlb_request_t    op_entry = '0;
   logic            resp_valid;
   logic            resp_ready = 1'b1;
   logic [1:0]      resp_op;
   logic            resp_probe_fail;
   logic [IW-1:0]   resp_index;
   tlb_request_t    resp_entry;
   logic            wired_we = 1'b0;
   logic [IW-1:0]   wired_wdata = '0;
   logic [IW-1:0]   random_value;
   logic [IW-1:0]   wired_value;
   search_request_t tlb_search;
   search_result_t  tlb_search_result;
   logic            tlb_write_enabled;
   logic [IW-1:0]   tlb_write_index;
   tlb_request_t    tlb_write_data;
   logic [IW-1:0]   tlb_read_index;
   tlb_request_t    tlb_read_data;

   tlb_request_t    tlb_mem [TLB_NUM];
   int              write_count = 0;
   int              overlap_count = 0;
   int              errors = 0;
   int              checks = 0;
   int              exp_rand [7] = '{14, 13, 12, 15, 14, 13, 12};

   tlb_request_t    e1;
   tlb_request_t    e2;
   tlb_request_t    ew;
   search_request_t k_hit;
   search_request_t k_miss;

   always #5 clock = ~clock;

   tlb_op_ctrl #(.TLB_NUM(TLB_NUM)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .op_valid(op_valid),
      .op_ready(op_ready),
      .op_code(op_code),
      .op_index(op_index),
      .op_search(op_search),
      .op_entry(op_entry),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_op(resp_op),
      .resp_probe_fail(resp_probe_fail),
      .resp_index(resp_index),
      .resp_entry(resp_entry),
      .wired_we(wired_we),
      .wired_wdata(wired_wdata),
      .random_value(random_value),
      .wired_value(wired_value),
      .tlb_search(tlb_search),
      .tlb_search_result(tlb_search_result),
      .tlb_write_enabled(tlb_write_enabled),
      .tlb_write_index(tlb_write_index),
      .tlb_write_data(tlb_write_data),
      .tlb_read_index(tlb_read_index),
      .tlb_read_data(tlb_read_data)
   );

   // Behavioural TLB: synchronous write, combinational read and lowest-index search
   always @(posedge clock) begin
      if (tlb_write_enabled) begin
         tlb_mem[tlb_write_index] <= tlb_write_data;
         write_count <= write_count + 1;
      end
   end

   assign tlb_read_data = tlb_mem[tlb_read_index];

   always_comb begin
      tlb_search_result = '0;
      for (int i = TLB_NUM - 1; i >= 0; i--) begin
         if (tlb_mem[i].virtual_page_number == tlb_search.virtual_page_number &&
             (tlb_mem[i].is_global || tlb_mem[i].asid == tlb_search.asid)) begin
            tlb_search_result.found = 1'b1;
            tlb_search_result.index = 8'(i);
            tlb_search_result.entry = tlb_mem[i];
         end
      end
   end

   always @(negedge clock) begin
      if (resp_valid && op_ready) overlap_count <= overlap_count + 1;
   end

   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Presents one request for a single cycle; returns with the DUT in EXEC
   task automatic applyStimulus(input logic [1:0] code, input logic [IW-1:0] index,
                                input search_request_t key, input tlb_request_t entry);
      op_valid  = 1'b1;
      op_code   = code;
      op_index  = index;
      op_search = key;
      op_entry  = entry;
      tick();
      op_valid  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < TLB_NUM; i++) tlb_mem[i] = '0;

      e1 = '0;
      e1.virtual_page_number = 19'h12345;
      e1.asid                = 8'h03;
      e1.is_global           = 1'b0;
      e1.even_page           = '{pfn: 20'hABCDE, cache: 3'd3, dirty: 1'b1, valid: 1'b1};
      e1.odd_page            = '{pfn: 20'h13579, cache: 3'd2, dirty: 1'b0, valid: 1'b1};
      e2 = '0;
      e2.virtual_page_number = 19'h00777;
      e2.asid                = 8'h09;
      e2.even_page           = '{pfn: 20'h55555, cache: 3'd1, dirty: 1'b1, valid: 1'b1};
      ew = '0;
      ew.virtual_page_number = 19'h00ABC;
      ew.asid                = 8'h01;
      ew.odd_page            = '{pfn: 20'h24680, cache: 3'd3, dirty: 1'b0, valid: 1'b1};
      k_hit  = '{virtual_page_number: 19'h12345, asid: 8'h03, is_odd_page: 1'b0};
      k_miss = '{virtual_page_number: 19'h12345, asid: 8'h04, is_odd_page: 1'b0};

      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_resp_valid", 128'(resp_valid), 128'(0));
      checkOutput("rst_write_en", 128'(tlb_write_enabled), 128'(0));
      checkOutput("rst_random", 128'(random_value), 128'(15));
      checkOutput("rst_wired", 128'(wired_value), 128'(0));
      reset_n = 1'b1;
      checkOutput("rst_op_ready", 128'(op_ready), 128'(1));
      for (int v = 14; v >= 12; v--) begin
         tick();
         checkOutput("idle_random", 128'(random_value), 128'(v));
      end

      applyStimulus(2'd2, 4'd5, '0, e1);
      checkOutput("wi_exec_we", 128'(tlb_write_enabled), 128'(1));
      checkOutput("wi_exec_idx", 128'(tlb_write_index), 128'(5));
      checkOutput("wi_exec_ready", 128'(op_ready), 128'(0));
      checkOutput("wi_exec_valid", 128'(resp_valid), 128'(0));
      tick();
      checkOutput("wi_resp_we", 128'(tlb_write_enabled), 128'(0));
      checkOutput("wi_resp_valid", 128'(resp_valid), 128'(1));
      checkOutput("wi_resp_op", 128'(resp_op), 128'(2));
      checkOutput("wi_resp_idx", 128'(resp_index), 128'(5));
      checkOutput("wi_writes", 128'(write_count), 128'(1));
      tick();
      checkOutput("wi_back_ready", 128'(op_ready), 128'(1));
      checkOutput("wi_back_valid", 128'(resp_valid), 128'(0));

      applyStimulus(2'd1, 4'd5, '0, '0);
      checkOutput("tlbr_exec_valid", 128'(resp_valid), 128'(0));
      tick();
      checkOutput("tlbr_valid", 128'(resp_valid), 128'(1));
      checkOutput("tlbr_entry", 128'(resp_entry), 128'(e1));
      checkOutput("tlbr_idx", 128'(resp_index), 128'(5));
      checkOutput("tlbr_op", 128'(resp_op), 128'(1));
      tick();

      applyStimulus(2'd0, 4'd0, k_hit, '0);
      tick();
      checkOutput("tlbp_hit_fail", 128'(resp_probe_fail), 128'(0));
      checkOutput("tlbp_hit_idx", 128'(resp_index), 128'(5));
      checkOutput("tlbp_hit_entry", 128'(resp_entry), 128'(0));
      tick();

      applyStimulus(2'd0, 4'd0, k_miss, '0);
      tick();
      checkOutput("tlbp_miss_fail", 128'(resp_probe_fail), 128'(1));
      checkOutput("tlbp_miss_idx", 128'(resp_index), 128'(0));
      tick();

      wired_we = 1'b1;
      wired_wdata = 4'd12;
      tick();
      wired_we = 1'b0;
      checkOutput("wired_value", 128'(wired_value), 128'(12));
      checkOutput("wired_random0", 128'(random_value), 128'(15));
      for (int i = 0; i < 7; i++) begin
         tick();
         checkOutput("wired_random", 128'(random_value), 128'(exp_rand[i]));
      end

      wired_we = 1'b1;
      wired_wdata = 4'd0;
      tick();
      wired_we = 1'b0;
      checkOutput("wr_pre_random", 128'(random_value), 128'(15));
      tick();
      tick();
      checkOutput("wr_accept_random", 128'(random_value), 128'(13));
      wired_we = 1'b1;
      wired_wdata = 4'd0;
      applyStimulus(2'd3, 4'd2, '0, ew);
      wired_we = 1'b0;
      checkOutput("wr_exec_we", 128'(tlb_write_enabled), 128'(1));
      checkOutput("wr_exec_idx", 128'(tlb_write_index), 128'(13));
      checkOutput("wr_next_random", 128'(random_value), 128'(15));
      tick();
      checkOutput("wr_resp_idx", 128'(resp_index), 128'(13));
      checkOutput("wr_resp_op", 128'(resp_op), 128'(3));
      checkOutput("wr_mem", 128'(tlb_mem[13]), 128'(ew));
      tick();

      resp_ready = 1'b0;
      applyStimulus(2'd1, 4'd5, '0, '0);
      tick();
      op_valid = 1'b1;
      op_code  = 2'd2;
      op_index = 4'd7;
      op_entry = e2;
      for (int i = 0; i < 4; i++) begin
         checkOutput("stall_valid", 128'(resp_valid), 128'(1));
         checkOutput("stall_ready", 128'(op_ready), 128'(0));
         checkOutput("stall_idx", 128'(resp_index), 128'(5));
         checkOutput("stall_entry", 128'(resp_entry), 128'(e1));
         checkOutput("stall_we", 128'(tlb_write_enabled), 128'(0));
         tick();
      end
      op_valid = 1'b0;
      resp_ready = 1'b1;
      tick();
      checkOutput("stall_release", 128'(op_ready), 128'(1));
      checkOutput("stall_writes", 128'(write_count), 128'(2));

      wired_we = 1'b1;
      wired_wdata = 4'd3;
      tick();
      wired_we = 1'b0;
      checkOutput("pre_rst_wired", 128'(wired_value), 128'(3));
      applyStimulus(2'd2, 4'd9, '0, e2);
      checkOutput("abort_exec_we", 128'(tlb_write_enabled), 128'(1));
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_we", 128'(tlb_write_enabled), 128'(0));
      checkOutput("abort_ready", 128'(op_ready), 128'(1));
      checkOutput("abort_valid", 128'(resp_valid), 128'(0));
      checkOutput("abort_idx", 128'(resp_index), 128'(0));
      checkOutput("abort_wr_idx", 128'(tlb_write_index), 128'(0));
      checkOutput("abort_op", 128'(resp_op), 128'(0));
      checkOutput("abort_random", 128'(random_value), 128'(15));
      checkOutput("abort_wired", 128'(wired_value), 128'(0));
      tick();
      checkOutput("abort_writes", 128'(write_count), 128'(2));
      checkOutput("abort_mem9", 128'(tlb_mem[9]), 128'(0));
      reset_n = 1'b1;
      tick();
      checkOutput("post_rst_ready", 128'(op_ready), 128'(1));
      checkOutput("post_rst_valid", 128'(resp_valid), 128'(0));
      checkOutput("never_overlap", 128'(overlap_count), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR) against the dual-search TLB. It sits between the CP0/exception unit and the TLB's write port, read port and second search port. It accepts one operation at a time over a valid/ready handshake and drives the TLB for one cycle. It returns the result over a valid/ready response channel, and owns the CP0 Random and Wired counters used for TLBWR.

## Interface
- TLB_NUM, 16, number of TLB entries; power of two, ≥ 4. IW = $clog2(TLB_NUM).
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept an operation.
- op_code  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
- op_index  in  IW  target index for TLBR/TLBWI.
- op_search  in  tlb_params::search_request_t  probe key for TLBP (virtual_page_number, asid, is_odd_page).
- op_entry  in  tlb_params::tlb_request_t  entry to write for TLBWI/TLBWR.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_op  out  2  op_code of the completed operation.
- resp_probe_fail  out  1  TLBP found no match (CP0 Index.P).
- resp_index  out  IW  TLBP hit index / TLBR index / index actually written.
- resp_entry  out  tlb_params::tlb_request_t  TLBR read data; zero for other ops.
- wired_we  in  1  write Wired register.
- wired_wdata  in  IW  new Wired value.
- random_value  out  IW  current Random register.
- wired_value  out  IW  current Wired register.
- tlb_search  out  tlb_params::search_request_t  to TLB search port 2.
- tlb_search_result  in  tlb_params::search_result_t  from TLB search port 2 (found, index, entry).
- tlb_write_enabled  out  1  to TLB write_enabled.
- tlb_write_index  out  IW  to TLB write_index.
- tlb_write_data  out  tlb_params::tlb_request_t  to TLB write_data.
- tlb_read_index  out  IW  to TLB read_index.
- tlb_read_data  in  tlb_params::tlb_request_t  from TLB read_data.

## Operation
- States: IDLE, EXEC, RESP. op_ready = (state == IDLE).
- IDLE: on op_valid & op_ready, latch op_code, op_search and op_entry, then go to EXEC. The latched index is op_index for TLBP/TLBR/TLBWI and random_value of that cycle for TLBWR.
- EXEC (one cycle):
  - TLBP: tlb_search presents the latched key. At the clock edge, latch probe_fail = ~found and resp_index = found ? index : 0.
  - TLBR: tlb_read_index = latched index. At the clock edge, latch resp_entry = tlb_read_data.
  - TLBWI/TLBWR: tlb_write_enabled = 1, tlb_write_index = latched index, tlb_write_data = latched entry.
  - After EXEC, go to RESP.
- RESP: resp_valid = 1, with all resp_* held stable. On resp_ready, go to IDLE.
- tlb_write_enabled is 1 only in EXEC for write ops; it is never asserted in any other state.
- tlb_search, tlb_read_index, tlb_write_index and tlb_write_data always reflect the latched registers.
- Random counter, updated every cycle:
  - If wired_we is asserted, or random_value ≤ wired_value, the next value is TLB_NUM-1.
  - Otherwise the next value is random_value - 1.
  - random_value therefore cycles over [Wired, TLB_NUM-1].
- Wired: wired_we loads wired_wdata. A value ≥ TLB_NUM-1 pins Random at TLB_NUM-1.
- Simultaneous wired_we and TLBWR acceptance: TLBWR uses the pre-update random_value.

## Timing
- Reset (asynchronous, reset_n = 0):
  - state = IDLE, so op_ready = 1 once reset releases.
  - resp_valid = 0, tlb_write_enabled = 0, and every latched/resp register = 0.
  - random_value = TLB_NUM-1, wired_value = 0.
- Latency: acceptance at edge N (EXEC during cycle N+1); resp_valid is high from cycle N+2.
- Minimum issue interval is 3 cycles when resp_ready is held high.
- The TLB write lands at the edge ending EXEC. A TLBP issued next sees the new entry.
- Reset asserted mid-operation aborts it. If asserted during EXEC before the edge, no write occurs. A pending response is discarded.
- resp_valid is never asserted while op_ready = 1.

## Test plan
- TLBWI index 5, entry VPN 0x12345, ASID 0x3, global 0 → tlb_write_enabled is one cycle, index 5. Then TLBR index 5 → resp_entry equals the written entry, resp_index 5, resp_valid 2 cycles after acceptance.
- TLBP, key VPN 0x12345 ASID 0x3 after the previous write → resp_probe_fail 0, resp_index 5. Key ASID 0x4 with global 0 → resp_probe_fail 1, resp_index 0.
- From reset, idle 3 cycles with wired 0 → random_value 15, 14, 13, 12.
- Set wired 12, then run 8 cycles → random_value sequence is 15, 14, 13, 12, 15, ….
- TLBWR accepted in the same cycle as wired_we → the written index equals the random_value of the accept cycle, and random_value is 15 next cycle.
- Hold resp_ready 0 for 4 cycles in RESP → resp_* stable, op_ready 0, and a second op_valid is not accepted.
- Assert reset_n low during EXEC of a TLBWI → no write, and all outputs reach their reset values.
